// File: rtl/multicycle_pkg.sv
// multicycle_pkg
//   Shared encodings for the multi-cycle RV32I controller: the main FSM
//   state enum, ALUOp / mux-select / immediate / ALU operation codes and
//   the opcodes the controller recognises.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   // ALUOp
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ResultSrc
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALUSrcA
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALUSrcB
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ImmSrc
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // ALUControl
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Opcodes
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

endpackage

// File: rtl/multicycle_alu_decoder.sv
// multicycle_alu_decoder
//   Combinational ALU operation decode.
//   alu_op      in  2  class of operation requested by the FSM
//   op5         in  1  opcode bit 5 (1 = R-type, separates sub from addi)
//   funct3      in  3  instruction funct3
//   funct7b5    in  1  instruction bit 30
//   alu_control out 3  ALU operation
module multicycle_alu_decoder
   import multicycle_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic       op5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB:   alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // bit 30 is only a sub flag for R-type; for addi it is immediate
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default:     alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
//   Main sequencing FSM for the multi-cycle RV32I core. Steps each
//   instruction through fetch/decode/execute/memory/writeback and drives
//   all datapath enables and selects combinationally from the state and
//   the instruction register fields.
//   clk, reset        clock, synchronous active-high reset
//   op/funct3/funct7b5 instruction register fields
//   Zero              ALU zero flag (used only in BEQ)
//   PCWrite..ALUControl datapath controls
//   illegal_op        pulse in DECODE for unsupported opcodes
//   instr_done        high in the last cycle of each instruction
//   state             current FSM state
module multicycle_control
   import multicycle_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       illegal_op,
   output logic       instr_done,
   output logic [3:0] state
);

   state_t     state_q, state_d;
   state_t     out_state;
   logic       op_legal;
   logic       pc_update;
   logic       branch;
   logic [1:0] alu_op;

   assign state = state_q;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                     (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);

   // next state
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // Outputs. During reset the selects present their FETCH values, so the
   // decode runs on FETCH and the enables are masked afterwards.
   assign out_state = reset ? S_FETCH : state_q;

   always_comb begin
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      pc_update  = 1'b0;
      branch     = 1'b0;
      illegal_op = 1'b0;
      instr_done = 1'b0;
      case (out_state)
         S_FETCH: begin
            IRWrite   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            pc_update = 1'b1;
         end
         S_DECODE: begin
            // OldPC + imm: branch target parked in ALUOut for BEQ
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_IMM;
            illegal_op = ~op_legal;
            instr_done = ~op_legal;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc  = RES_DATA;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            MemWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA    = SRCA_RS1;
            alu_op     = ALUOP_SUB;
            branch     = 1'b1;
            instr_done = 1'b1;
         end
         S_JAL: begin
            // PC <= ALUOut (target from DECODE); ALU forms OldPC+4 for rd
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         IRWrite    = 1'b0;
         RegWrite   = 1'b0;
         MemWrite   = 1'b0;
         pc_update  = 1'b0;
         branch     = 1'b0;
         illegal_op = 1'b0;
         instr_done = 1'b0;
      end
   end

   assign PCWrite = pc_update | (branch & Zero);

   always_comb begin
      case (op)
         OP_SW:   ImmSrc = IMM_S;
         OP_BEQ:  ImmSrc = IMM_B;
         OP_JAL:  ImmSrc = IMM_J;
         default: ImmSrc = IMM_I;
      endcase
   end

   multicycle_alu_decoder u_alu_dec (
      .alu_op      (alu_op),
      .op5         (op[5]),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .alu_control (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Scoreboard bench: each instruction issued pushes its expected per-cycle
//   control words; a monitor pops and compares one word every cycle.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5, Zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic       illegal_op, instr_done;
   logic [3:0] state;

   multicycle_control dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .ALUControl(ALUControl), .illegal_op(illegal_op),
      .instr_done(instr_done), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, adr, mw, irw, rw;
      logic [1:0] rs, sa, sb, imm;
      logic [2:0] alu;
      logic       ill, done;
   } exp_t;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                          IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_push;
   exp_t mon_e, mon_a;

   function automatic logic is_legal(input logic [6:0] o);
      return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
   endfunction

   // Operation the ALU should perform for an arithmetic instruction.
   function automatic logic [2:0] alu_for(input logic is_r, input logic [2:0] f3,
                                          input logic f7);
      case (f3)
         3'd0:    return (is_r && f7) ? 3'b001 : 3'b000;
         3'd2:    return 3'b101;
         3'd6:    return 3'b011;
         3'd7:    return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Expected word with all controls idle; immediate format follows op.
   function automatic exp_t idle(input int st, input logic [6:0] o);
      exp_t e = '0;
      e.st  = 4'(st);
      e.imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
      return e;
   endfunction

   // PC <= PC+4, IR <= mem[PC]
   function automatic exp_t fetch_word(input logic [6:0] o);
      exp_t e = idle(0, o);
      e.pcw = 1; e.irw = 1; e.sb = 2'b10; e.rs = 2'b10;
      return e;
   endfunction

   // Reset cycle: FETCH selects with every write enable quiet.
   function automatic exp_t reset_word(input int st, input logic [6:0] o);
      exp_t e = fetch_word(o);
      e.st = 4'(st); e.pcw = 0; e.irw = 0;
      return e;
   endfunction

   task automatic push(input exp_t e);
      exp_q.push_back(e);
      n_push++;
   endtask

   // Issue one instruction starting at its FETCH cycle (called just after
   // the edge that enters FETCH); returns just after the edge ending it.
   task automatic run(input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z);
      exp_t e;
      op = o; funct3 = f3; funct7b5 = f7; Zero = z;
      n_push = 0;
      push(fetch_word(o));
      e = idle(1, o); e.sa = 2'b01; e.sb = 2'b01;
      if (!is_legal(o)) begin e.ill = 1; e.done = 1; end
      push(e);
      if (o == LW || o == SW) begin
         e = idle(2, o); e.sa = 2'b10; e.sb = 2'b01; push(e);
         if (o == LW) begin
            e = idle(3, o); e.adr = 1; push(e);
            e = idle(4, o); e.rs = 2'b01; e.rw = 1; e.done = 1; push(e);
         end else begin
            e = idle(5, o); e.adr = 1; e.mw = 1; e.done = 1; push(e);
         end
      end else if (o == RT || o == IT) begin
         e = idle(o == RT ? 6 : 7, o); e.sa = 2'b10;
         e.sb = (o == RT) ? 2'b00 : 2'b01;
         e.alu = alu_for(o == RT, f3, f7); push(e);
         e = idle(8, o); e.rw = 1; e.done = 1; push(e);
      end else if (o == BQ) begin
         e = idle(9, o); e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; e.done = 1;
         push(e);
      end else if (o == JL) begin
         e = idle(10, o); e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; push(e);
         e = idle(8, o); e.rw = 1; e.done = 1; push(e);
      end
      repeat (n_push) @(posedge clk);
      #1;
   endtask

   // lw interrupted by reset while in MEMREAD.
   task automatic run_reset_in_memread();
      exp_t e;
      op = LW; funct3 = 3'd2; funct7b5 = 0; Zero = 0;
      push(fetch_word(LW));
      e = idle(1, LW); e.sa = 2'b01; e.sb = 2'b01; push(e);
      e = idle(2, LW); e.sa = 2'b10; e.sb = 2'b01; push(e);
      push(reset_word(3, LW));
      repeat (3) @(posedge clk);
      #1 reset = 1;
      @(posedge clk);
      #1 reset = 0;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_a = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op, instr_done};
         n_vec++;
         if (mon_a !== mon_e) begin
            n_bad++;
            $display("FAIL ctrl word %0d (op %b): got %h (state %0d) want %h (state %0d)",
                     n_vec, op, mon_a, mon_a.st, mon_e, mon_e.st);
         end
      end
   end

   initial begin
      logic [6:0] o;
      int k;
      reset = 1; op = LW; funct3 = 0; funct7b5 = 0; Zero = 0;
      @(posedge clk);
      #1 exp_q.push_back(reset_word(0, LW));
      @(posedge clk);
      #1 reset = 0;

      run(LW, 3'd2, 0, 0);
      run(SW, 3'd2, 1, 1);
      run(RT, 3'd0, 1, 0);      // sub
      run(IT, 3'd0, 1, 0);      // addi with bit30 set stays add
      run(BQ, 3'd0, 0, 1);      // taken
      run(BQ, 3'd0, 0, 0);      // not taken
      run(JL, 3'd5, 1, 1);
      run(7'b0000000, 3'd0, 0, 1);
      run_reset_in_memread();
      run(RT, 3'd7, 0, 1);

      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 6);
         case (k)
            0: o = LW;
            1: o = SW;
            2: o = RT;
            3: o = IT;
            4: o = BQ;
            5: o = JL;
            default: begin
               o = 7'($urandom);
               while (is_legal(o)) o = 7'($urandom);
            end
         endcase
         if ($urandom_range(0, 40) == 0) run_reset_in_memread();
         run(o, 3'($urandom), 1'($urandom), 1'($urandom));
      end

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected words left, want 0", exp_q.size());
      end
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
